// File: rtl/cpu_pkg.sv
// Shared LEGv8 CPU definitions: fetch FSM states, instruction field positions,
// NZVC flag indices and the opcode patterns used by the control unit and fetch stage.
package cpu_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  localparam int OPC_MSB    = 31;
  localparam int OPC_LSB    = 21;
  localparam int BR26_MSB   = 25;
  localparam int BR26_LSB   = 0;
  localparam int COND19_MSB = 23;
  localparam int COND19_LSB = 5;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  // Branch formats are matched on their leading bits only; R-format on all 11.
  localparam logic [5:0]  OPC_B     = 6'b000101;
  localparam logic [7:0]  OPC_CBZ   = 8'b10110100;
  localparam logic [7:0]  OPC_BCOND = 8'b01010100;
  localparam logic [10:0] OPC_ADD   = 11'b10001011000;
  localparam logic [10:0] OPC_SUB   = 11'b11001011000;
  localparam logic [10:0] OPC_SUBS  = 11'b11101011000;

endpackage

// File: rtl/flagreg.sv
// 4-bit NZVC condition-flag register with load enable and asynchronous reset.
module flagreg (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] r_flags;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     r_flags <= 4'b0000;
    else if (en) r_flags <= d;
  end

  assign q = r_flags;

endmodule

// File: rtl/fetch_unit.sv
// LEGv8 fetch/PC-sequencing stage: two-state FETCH/EXEC FSM, instruction register,
// NZVC flag register and B/CBZ/BLT resolution.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                  ADDR_W   = 64,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              imem_ready,
  input  logic [31:0]       instr,
  input  logic              UBranch,
  input  logic              Branch,
  input  logic              Brsel,
  input  logic              FlagEn,
  input  logic              alu_zero,
  input  logic              alu_negative,
  input  logic              alu_overflow,
  input  logic              alu_carry,
  output logic              imem_req,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       ir,
  output logic [10:0]       opcode,
  output logic              instr_valid,
  output logic [3:0]        flags,
  output logic              taken
);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [31:0]         r_ir;
  logic                r_imem_req;
  logic                r_instr_valid;

  logic                w_exec;
  logic [3:0]          w_flags;
  logic                w_cond;
  logic                w_taken;
  logic [ADDR_W-1:0]   w_off26;
  logic [ADDR_W-1:0]   w_off19;
  logic [ADDR_W-1:0]   w_step;
  logic [ADDR_W-1:0]   w_next_pc;

  assign w_exec = (r_state == EXEC);

  flagreg u_flagreg (
    .clk (clk),
    .rst (reset),
    .en  (w_exec & FlagEn),
    .d   ({alu_negative, alu_zero, alu_overflow, alu_carry}),
    .q   (w_flags)
  );

  // BLT reads the registered flags, so a same-cycle FlagEn only affects the next instruction.
  assign w_cond  = Brsel ? (w_flags[FLAG_N] ^ w_flags[FLAG_V]) : alu_zero;
  assign w_taken = w_exec & (UBranch | (Branch & w_cond));

  assign w_off26 = {{(ADDR_W-28){r_ir[BR26_MSB]}}, r_ir[BR26_MSB:BR26_LSB], 2'b00};
  assign w_off19 = {{(ADDR_W-21){r_ir[COND19_MSB]}}, r_ir[COND19_MSB:COND19_LSB], 2'b00};
  assign w_step  = !w_taken ? {{(ADDR_W-3){1'b0}}, 3'd4} :
                   UBranch  ? w_off26 : w_off19;
  assign w_next_pc = r_pc + w_step;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= FETCH;
      r_pc          <= RESET_PC;
      r_ir          <= 32'h0;
      r_imem_req    <= 1'b1;
      r_instr_valid <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (imem_ready) begin
            r_ir          <= instr;
            r_state       <= EXEC;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b1;
          end
        end
        EXEC: begin
          r_pc          <= w_next_pc;
          r_state       <= FETCH;
          r_imem_req    <= 1'b1;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign instr_valid = r_instr_valid;
  assign pc          = r_pc;
  assign ir          = r_ir;
  assign opcode      = r_ir[OPC_MSB:OPC_LSB];
  assign flags       = w_flags;
  assign taken       = w_taken;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a driver issues instructions and queues the expected
// EXEC-cycle view; a monitor compares it whenever instr_valid is presented.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ready;
  logic [31:0] instr;
  logic        UBranch, Branch, Brsel, FlagEn;
  logic        alu_zero, alu_negative, alu_overflow, alu_carry;
  logic        imem_req;
  logic [63:0] pc;
  logic [31:0] ir;
  logic [10:0] opcode;
  logic        instr_valid;
  logic [3:0]  flags;
  logic        taken;

  typedef struct {
    logic [63:0] pc;
    logic [10:0] opc;
    logic        tk;
    logic [3:0]  fl;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_pc = 64'h0;
  logic [3:0]  exp_flags = 4'h0;

  fetch_unit #(.ADDR_W(64), .RESET_PC(64'h0)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_ready   (imem_ready),
    .instr        (instr),
    .UBranch      (UBranch),
    .Branch       (Branch),
    .Brsel        (Brsel),
    .FlagEn       (FlagEn),
    .alu_zero     (alu_zero),
    .alu_negative (alu_negative),
    .alu_overflow (alu_overflow),
    .alu_carry    (alu_carry),
    .imem_req     (imem_req),
    .pc           (pc),
    .ir           (ir),
    .opcode       (opcode),
    .instr_valid  (instr_valid),
    .flags        (flags),
    .taken        (taken)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares the EXEC-cycle outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && instr_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_underflow: got instr_valid=1 expected no pending instruction");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("exec_pc",     pc,          e.pc);
        check("exec_opcode", 64'(opcode), 64'(e.opc));
        check("exec_taken",  64'(taken),  64'(e.tk));
        check("exec_flags",  64'(flags),  64'(e.fl));
        check("exec_req",    64'(imem_req), 64'd0);
      end
    end
  end

  task automatic clear_ctrl();
    UBranch = 0; Branch = 0; Brsel = 0; FlagEn = 0;
    alu_negative = 0; alu_zero = 0; alu_overflow = 0; alu_carry = 0;
  endtask

  // Called at posedge+1 with the DUT in FETCH. nzvc = {N,Z,V,C} presented by the ALU.
  task automatic run_instr(input logic [31:0] ins, input int waits,
                           input logic ub, input logic br, input logic bs, input logic fe,
                           input logic [3:0] nzvc, input logic exp_tk,
                           input logic [63:0] exp_next);
    imem_ready = 0;
    for (int k = 0; k < waits; k++) begin
      @(posedge clk); #1;
      check("wait_pc_hold", pc, exp_pc);
      check("wait_req",     64'(imem_req), 64'd1);
    end
    imem_ready = 1; instr = ins;
    UBranch = ub; Branch = br; Brsel = bs; FlagEn = fe;
    {alu_negative, alu_zero, alu_overflow, alu_carry} = nzvc;
    sb.push_back('{pc: exp_pc, opc: ins[31:21], tk: exp_tk, fl: exp_flags});
    @(posedge clk); #1;
    imem_ready = 0; instr = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    if (fe) exp_flags = nzvc;
    check("next_pc",       pc,              exp_next);
    check("next_flags",    64'(flags),      64'(exp_flags));
    check("fetch_taken",   64'(taken),      64'd0);
    check("fetch_req",     64'(imem_req),   64'd1);
    check("fetch_valid",   64'(instr_valid), 64'd0);
    clear_ctrl();
    exp_pc = exp_next;
  endtask

  initial begin
    reset = 1; imem_ready = 0; instr = 32'h0;
    clear_ctrl();
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc",     pc,               64'h0);
    check("rst_req",    64'(imem_req),    64'd1);
    check("rst_valid",  64'(instr_valid), 64'd0);
    check("rst_flags",  64'(flags),       64'd0);
    check("rst_opcode", 64'(opcode),      64'd0);
    check("rst_taken",  64'(taken),       64'd0);
    reset = 0;

    // B +16 to reach 0x40, then assert reset in the middle of EXEC.
    run_instr(32'h1400_0010, 0, 1, 0, 0, 0, 4'b0000, 1, 64'h40);
    imem_ready = 1; instr = 32'h8B02_0020; FlagEn = 1; alu_negative = 1;
    @(posedge clk); #1;
    check("midexec_valid", 64'(instr_valid), 64'd1);
    reset = 1;
    #1;
    check("midrst_pc",     pc,               64'h0);
    check("midrst_req",    64'(imem_req),    64'd1);
    check("midrst_valid",  64'(instr_valid), 64'd0);
    check("midrst_flags",  64'(flags),       64'd0);
    check("midrst_opcode", 64'(opcode),      64'd0);
    imem_ready = 0; clear_ctrl();
    @(posedge clk); #1;
    reset = 0;
    exp_pc = 64'h0; exp_flags = 4'h0;

    // Sequential fetch, including a three-cycle memory stall at 0x8.
    run_instr(32'h8B02_0020, 0, 0, 0, 0, 0, 4'b0000, 0, 64'h4);
    run_instr(32'h8B02_0020, 0, 0, 0, 0, 0, 4'b0000, 0, 64'h8);
    run_instr(32'h8B02_0020, 3, 0, 0, 0, 0, 4'b0000, 0, 64'hC);

    // B to 0x100, then B -1.
    run_instr(32'h1400_003D, 0, 1, 0, 0, 0, 4'b0000, 1, 64'h100);
    run_instr(32'h17FF_FFFF, 0, 1, 0, 0, 0, 4'b0000, 1, 64'hFC);

    // CBZ imm19=3 at 0x20, taken then not taken.
    run_instr(32'h17FF_FFC9, 0, 1, 0, 0, 0, 4'b0000, 1, 64'h20);
    run_instr(32'hB400_0061, 0, 0, 1, 0, 0, 4'b0100, 1, 64'h2C);
    run_instr(32'h17FF_FFFD, 0, 1, 0, 0, 0, 4'b0000, 1, 64'h20);
    run_instr(32'hB400_0061, 0, 0, 1, 0, 0, 4'b0000, 0, 64'h24);

    // SUBS sets N, then BLT -2 at 0x14 (alu_zero low so the CBZ path would differ).
    run_instr(32'hEB02_0020, 0, 0, 0, 0, 1, 4'b1000, 0, 64'h28);
    run_instr(32'h17FF_FFFB, 0, 1, 0, 0, 0, 4'b0000, 1, 64'h14);
    run_instr(32'h54FF_FFCB, 0, 0, 1, 1, 0, 4'b0000, 1, 64'hC);

    // SUBS sets N=V=1, BLT at 0x14 falls through (alu_zero high).
    run_instr(32'hEB02_0020, 0, 0, 0, 0, 1, 4'b1010, 0, 64'h10);
    run_instr(32'h1400_0001, 0, 1, 0, 0, 0, 4'b0000, 1, 64'h14);
    run_instr(32'h54FF_FFCB, 0, 0, 1, 1, 0, 4'b0100, 0, 64'h18);

    // BLT with FlagEn in the same cycle uses the old flags; the next BLT sees the new ones.
    run_instr(32'h54FF_FFCB, 0, 0, 1, 1, 1, 4'b1000, 0, 64'h1C);
    run_instr(32'h54FF_FFCB, 0, 0, 1, 1, 0, 4'b0000, 1, 64'h14);

    // Address wrap in both directions.
    run_instr(32'h17FF_FFFB, 0, 1, 0, 0, 0, 4'b0000, 1, 64'h0);
    run_instr(32'h17FF_FFFF, 0, 1, 0, 0, 0, 4'b0000, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    run_instr(32'h8B02_0020, 1, 0, 0, 0, 0, 4'b0000, 0, 64'h0);

    @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
